// File: rtl/io_input_cond.sv
// Input conditioner for board switches and active-low push-buttons: two-flop sync,
// per-bit debounce, sticky press events and a wrapping press counter for the LSU read path.
module io_input_cond #(
    parameter int unsigned SW_W      = 18,
    parameter int unsigned BTN_W     = 4,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [BTN_W-1:0] btn_raw_n,
    input  logic             btn_clr,
    input  logic [3:0]       btn_clr_mask,
    output logic [31:0]      io_sw,
    output logic [31:0]      io_btn
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam int unsigned NB    = SW_W + BTN_W;
    localparam logic [NB-1:0]    SYNC_IDLE = {{BTN_W{1'b1}}, {SW_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);

    logic [NB-1:0]    s1_q, s2_q;
    logic [NB-1:0]    db_in;
    logic [NB-1:0]    stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [BTN_W-1:0] btn_lvl, btn_lvl_prev_q, rise;
    logic [BTN_W-1:0] clr_mask, evt_q, evt_d;
    logic [7:0]       press_q, press_d;

    // Buttons and switches share one sync/debounce vector; buttons sit in the top bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= SYNC_IDLE;
            s2_q           <= SYNC_IDLE;
            stable_q       <= '0;
            btn_lvl_prev_q <= '0;
            evt_q          <= '0;
            press_q        <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q           <= {btn_raw_n, sw_raw};
            s2_q           <= s1_q;
            stable_q       <= stable_d;
            btn_lvl_prev_q <= btn_lvl;
            evt_q          <= evt_d;
            press_q        <= press_d;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Buttons flipped to pressed-high after the synchroniser.
    assign db_in = {~s2_q[NB-1:SW_W], s2_q[SW_W-1:0]};

    // Counter restarts whenever the input agrees with the debounced level.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (db_in[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = db_in[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_lvl  = stable_q[NB-1:SW_W];
    assign rise     = btn_lvl & ~btn_lvl_prev_q;
    assign clr_mask = btn_clr ? btn_clr_mask[BTN_W-1:0] : '0;

    // A new press outranks a same-cycle clear; the counter counts cycles with any press.
    always_comb begin
        evt_d   = (evt_q & ~clr_mask) | rise;
        press_d = press_q;
        if (|rise) begin
            press_d = press_q + 8'd1;
        end
    end

    assign io_sw  = 32'(stable_q[SW_W-1:0]);
    assign io_btn = {16'h0000, press_q, 4'(evt_q), 4'(btn_lvl)};

endmodule
